// File: rtl/motor_pkg.sv
// Shared Hall-sensor definitions for the position decoder and the commutation tables.
// Sector numbering follows forward rotation order 0..5.
package motor_pkg;

    typedef logic [2:0] hall_code_t;
    typedef logic [2:0] sector_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_SKIP
    } step_t;

    localparam hall_code_t HALL_S0   = 3'b101;
    localparam hall_code_t HALL_S1   = 3'b100;
    localparam hall_code_t HALL_S2   = 3'b110;
    localparam hall_code_t HALL_S3   = 3'b010;
    localparam hall_code_t HALL_S4   = 3'b011;
    localparam hall_code_t HALL_S5   = 3'b001;
    localparam hall_code_t HALL_ILL0 = 3'b000;
    localparam hall_code_t HALL_ILL1 = 3'b111;

    function automatic logic sector_valid(input hall_code_t code);
        return (code != HALL_ILL0) && (code != HALL_ILL1);
    endfunction

    function automatic sector_t hall_to_sector(input hall_code_t code);
        sector_t s;
        case (code)
            HALL_S0: s = 3'd0;
            HALL_S1: s = 3'd1;
            HALL_S2: s = 3'd2;
            HALL_S3: s = 3'd3;
            HALL_S4: s = 3'd4;
            HALL_S5: s = 3'd5;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

    // Forward distance from one sector to another, modulo 6.
    function automatic logic [2:0] sector_delta(input sector_t to_s, input sector_t from_s);
        return (to_s >= from_s) ? 3'(to_s - from_s) : 3'(to_s + 3'd6 - from_s);
    endfunction

endpackage

// File: rtl/hall_input_filter.sv
// Two-flop synchroniser plus stable-count glitch filter for the three Hall lines.
// Emits a one-cycle accept pulse when a new code has been stable long enough.
module hall_input_filter
    import motor_pkg::*;
#(
    parameter int FILTER_CYCLES = 8
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  hall_code_t hall_i,
    output hall_code_t code_o,
    output logic       accept_o
);

    localparam logic [7:0] FILTER_MAX = 8'(FILTER_CYCLES);

    hall_code_t sync1_q;
    hall_code_t sync2_q;
    hall_code_t cand_q;
    hall_code_t accepted_q;
    logic [7:0] count_q;
    logic [1:0] primed_q;
    logic       accepted_valid_q;

    // The filter ignores the synchroniser until it holds real samples rather than reset zeros.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q          <= '0;
            sync2_q          <= '0;
            cand_q           <= '0;
            accepted_q       <= '0;
            count_q          <= '0;
            primed_q         <= '0;
            accepted_valid_q <= 1'b0;
        end else begin
            sync1_q  <= hall_i;
            sync2_q  <= sync1_q;
            primed_q <= {primed_q[0], 1'b1};
            if (primed_q[1]) begin
                if (sync2_q != cand_q) begin
                    cand_q  <= sync2_q;
                    count_q <= 8'd1;
                end else if (count_q != FILTER_MAX) begin
                    count_q <= count_q + 8'd1;
                end
            end
            if (accept_o) begin
                accepted_q       <= cand_q;
                accepted_valid_q <= 1'b1;
            end
        end
    end

    assign accept_o = (count_q == FILTER_MAX) && (!accepted_valid_q || (cand_q != accepted_q));
    assign code_o   = cand_q;

endmodule

// File: rtl/hall_position_decoder.sv
// Turns filtered Hall codes into sector, signed step position, step period and error flags.
// The position output is the feedback for the position controller.
module hall_position_decoder
    import motor_pkg::*;
#(
    parameter int FILTER_CYCLES = 8,
    parameter int PERIOD_WIDTH  = 24
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    hall1,
    input  logic                    hall2,
    input  logic                    hall3,
    input  logic                    clear_position,
    output logic signed [31:0]      position,
    output logic [2:0]              sector,
    output logic                    direction,
    output logic                    step_strobe,
    output logic [PERIOD_WIDTH-1:0] velocity_period,
    output logic                    stalled,
    output logic                    hall_error
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = {PERIOD_WIDTH{1'b1}};

    hall_code_t filt_code;
    logic       filt_accept;

    logic signed [31:0]      position_q, position_d;
    sector_t                 sector_q, sector_d;
    logic                    direction_q, direction_d;
    logic                    strobe_q, strobe_d;
    logic [PERIOD_WIDTH-1:0] counter_q, counter_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic                    stalled_q, stalled_d;
    logic                    hall_error_q, hall_error_d;
    logic                    init_q, init_d;

    step_t      step_d;
    logic       err_event_d;
    sector_t    new_sector;
    logic [2:0] delta;

    hall_input_filter #(
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
        .clock_i (CLK),
        .reset_i (reset),
        .hall_i  ({hall1, hall2, hall3}),
        .code_o  (filt_code),
        .accept_o(filt_accept)
    );

    assign new_sector = hall_to_sector(filt_code);
    assign delta      = sector_delta(new_sector, sector_q);

    // Classify each accepted code; skipped sectors resync rather than count.
    always_comb begin
        step_d      = STEP_NONE;
        err_event_d = 1'b0;
        sector_d    = sector_q;
        init_d      = init_q;
        if (filt_accept) begin
            if (!sector_valid(filt_code)) begin
                err_event_d = 1'b1;
            end else if (!init_q) begin
                sector_d = new_sector;
                init_d   = 1'b1;
            end else begin
                sector_d = new_sector;
                case (delta)
                    3'd0:    step_d = STEP_NONE;
                    3'd1:    step_d = STEP_FWD;
                    3'd5:    step_d = STEP_REV;
                    default: begin
                        step_d      = STEP_SKIP;
                        err_event_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        position_d  = position_q;
        direction_d = direction_q;
        strobe_d    = 1'b0;
        case (step_d)
            STEP_FWD: begin
                position_d  = position_q + 32'sd1;
                direction_d = 1'b1;
                strobe_d    = 1'b1;
            end
            STEP_REV: begin
                position_d  = position_q - 32'sd1;
                direction_d = 1'b0;
                strobe_d    = 1'b1;
            end
            default: ;
        endcase
        if (clear_position) position_d = '0;
        hall_error_d = clear_position ? err_event_d : (hall_error_q | err_event_d);

        // A saturated counter means the true period no longer fits, so report all-ones.
        counter_d = counter_q;
        period_d  = period_q;
        stalled_d = stalled_q;
        if (strobe_d) begin
            counter_d = '0;
            period_d  = (counter_q == PERIOD_MAX) ? PERIOD_MAX : counter_q + PERIOD_WIDTH'(1);
            stalled_d = 1'b0;
        end else if (counter_q == PERIOD_MAX) begin
            stalled_d = 1'b1;
            period_d  = PERIOD_MAX;
        end else begin
            counter_d = counter_q + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            position_q   <= '0;
            sector_q     <= '0;
            direction_q  <= 1'b1;
            strobe_q     <= 1'b0;
            counter_q    <= '0;
            period_q     <= PERIOD_MAX;
            stalled_q    <= 1'b1;
            hall_error_q <= 1'b0;
            init_q       <= 1'b0;
        end else begin
            position_q   <= position_d;
            sector_q     <= sector_d;
            direction_q  <= direction_d;
            strobe_q     <= strobe_d;
            counter_q    <= counter_d;
            period_q     <= period_d;
            stalled_q    <= stalled_d;
            hall_error_q <= hall_error_d;
            init_q       <= init_d;
        end
    end

    assign position        = position_q;
    assign sector          = sector_q;
    assign direction       = direction_q;
    assign step_strobe     = strobe_q;
    assign velocity_period = period_q;
    assign stalled         = stalled_q;
    assign hall_error      = hall_error_q;

endmodule

// File: tb/tb_hall_position_decoder.sv
// Bench for hall_position_decoder: directed scenarios then random Hall sequences,
// checked against an event-level model of sector stepping and step timing.
module tb_hall_position_decoder;

    localparam int FC   = 8;
    localparam int PW   = 8;
    localparam int LAT  = FC + 3;
    localparam int PMAX = (1 << PW) - 1;

    logic                 CLK = 1'b0;
    logic                 reset = 1'b0;
    logic                 hall1 = 1'b1;
    logic                 hall2 = 1'b0;
    logic                 hall3 = 1'b1;
    logic                 clear_position = 1'b0;
    logic signed [31:0]   position;
    logic [2:0]           sector;
    logic                 direction;
    logic                 step_strobe;
    logic [PW-1:0]        velocity_period;
    logic                 stalled;
    logic                 hall_error;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [2:0] hallCodes [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    logic signed [31:0] expPos;
    int                 expSector;
    logic               expDir;
    logic               expErr;
    logic               modelInit;
    logic               haveStrobe;
    int                 lastAcc;
    int                 lastRef;
    int                 expPeriod;

    hall_position_decoder #(
        .FILTER_CYCLES(FC),
        .PERIOD_WIDTH (PW)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .hall1          (hall1),
        .hall2          (hall2),
        .hall3          (hall3),
        .clear_position (clear_position),
        .position       (position),
        .sector         (sector),
        .direction      (direction),
        .step_strobe    (step_strobe),
        .velocity_period(velocity_period),
        .stalled        (stalled),
        .hall_error     (hall_error)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)",
                     tag, $signed(observed), $signed(expected), cycle);
        end
    endtask

    function automatic int sectorOf(input logic [2:0] code);
        for (int k = 0; k < 6; k++) if (hallCodes[k] == code) return k;
        return -1;
    endfunction

    task automatic checkState(input string where);
        logic eStall;
        int   eVp;
        if (!haveStrobe) begin
            eStall = 1'b1;
            eVp    = PMAX;
        end else begin
            eStall = (cycle - lastRef) >= (PMAX + 1);
            eVp    = eStall ? PMAX : expPeriod;
        end
        checkOutput({where, " position"},  position,        expPos);
        checkOutput({where, " sector"},    {29'd0, sector}, expSector);
        checkOutput({where, " direction"}, {31'd0, direction}, {31'd0, expDir});
        checkOutput({where, " hall_error"}, {31'd0, hall_error}, {31'd0, expErr});
        checkOutput({where, " stalled"},   {31'd0, stalled}, {31'd0, eStall});
        checkOutput({where, " period"},    {24'd0, velocity_period}, eVp);
    endtask

    task automatic resetDut();
        @(negedge CLK);
        reset          = 1'b1;
        clear_position = 1'b0;
        repeat (3) @(posedge CLK);
        #1 lastRef = cycle;
        @(negedge CLK);
        reset      = 1'b0;
        expPos     = '0;
        expSector  = 0;
        expDir     = 1'b1;
        expErr     = 1'b0;
        modelInit  = 1'b0;
        haveStrobe = 1'b0;
        lastAcc    = -1;
        checkOutput("reset strobe", {31'd0, step_strobe}, 32'd0);
        checkState("reset");
    endtask

    task automatic pulseClear();
        @(negedge CLK);
        clear_position = 1'b1;
        @(posedge CLK);
        #1 clear_position = 1'b0;
        expPos = '0;
        expErr = 1'b0;
        checkState("clear");
    endtask

    // Drive a code for 'hold' cycles; clearAt is 0 (none) or LAT (coincident with acceptance).
    task automatic applyStimulus(input logic [2:0] code, input int hold, input int clearAt);
        int   strobes;
        int   strobeAt;
        int   base;
        int   newIdx;
        int   delta;
        logic accepted;
        logic expStrobe;
        logic errEvent;
        @(negedge CLK);
        {hall1, hall2, hall3} = code;
        base     = cycle;
        strobes  = 0;
        strobeAt = -1;
        for (int i = 1; i <= hold; i++) begin
            clear_position = (i == clearAt);
            @(posedge CLK);
            #1;
            if (step_strobe) begin
                strobes++;
                if (strobeAt < 0) strobeAt = i;
            end
        end
        clear_position = 1'b0;

        accepted  = (hold >= LAT) && (int'(code) != lastAcc);
        expStrobe = 1'b0;
        errEvent  = 1'b0;
        if (accepted) begin
            lastAcc = int'(code);
            newIdx  = sectorOf(code);
            if (newIdx < 0) begin
                errEvent = 1'b1;
            end else if (!modelInit) begin
                modelInit = 1'b1;
                expSector = newIdx;
            end else begin
                delta = (newIdx - expSector + 6) % 6;
                if (delta == 1) begin
                    expPos    = expPos + 32'sd1;
                    expDir    = 1'b1;
                    expStrobe = 1'b1;
                end else if (delta == 5) begin
                    expPos    = expPos - 32'sd1;
                    expDir    = 1'b0;
                    expStrobe = 1'b1;
                end else if (delta != 0) begin
                    errEvent = 1'b1;
                end
                expSector = newIdx;
            end
            if (errEvent) expErr = 1'b1;
        end
        if (clearAt >= 1 && clearAt <= hold) begin
            expPos = '0;
            expErr = errEvent;
        end
        if (expStrobe) begin
            expPeriod  = (base + LAT - lastRef > PMAX) ? PMAX : base + LAT - lastRef;
            lastRef    = base + LAT;
            haveStrobe = 1'b1;
        end

        checkOutput("strobe count", strobes, {31'd0, expStrobe});
        if (expStrobe) checkOutput("strobe latency", strobeAt, LAT);
        checkState("step");
    endtask

    initial begin
        logic [2:0] curCode;
        logic [2:0] nxt;
        int         r;
        int         idx;
        int         hold;
        int         clearAt;

        resetDut();
        applyStimulus(3'b101, 20, 0);

        applyStimulus(3'b100, 100, 0);
        applyStimulus(3'b110, 100, 0);
        applyStimulus(3'b010, 100, 0);
        applyStimulus(3'b011, 100, 0);
        applyStimulus(3'b001, 100, 0);
        applyStimulus(3'b101, 100, 0);
        checkOutput("six forward steps", position, 32'sd6);

        pulseClear();
        applyStimulus(3'b001, 100, 0);
        applyStimulus(3'b011, 100, 0);
        checkOutput("two reverse steps", position, -32'sd2);

        applyStimulus(3'b001, 100, 0);
        applyStimulus(3'b101, 100, 0);

        applyStimulus(3'b100, 5, 0);
        applyStimulus(3'b101, 20, 0);
        applyStimulus(3'b100, 3, 0);
        applyStimulus(3'b101, 20, 0);

        applyStimulus(3'b111, 30, 0);
        applyStimulus(3'b101, 30, 0);
        applyStimulus(3'b110, 30, 0);
        pulseClear();

        applyStimulus(3'b010, 300, 0);
        applyStimulus(3'b011, 40, 0);

        applyStimulus(3'b001, 50, LAT);
        applyStimulus(3'b110, 50, LAT);

        applyStimulus(3'b010, 5, 0);
        resetDut();
        applyStimulus(3'b010, 20, 0);
        curCode = 3'b010;

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                nxt = hallCodes[$urandom_range(0, 5)];
                if (nxt == curCode) nxt = ~curCode;
                applyStimulus(nxt, $urandom_range(1, 6), 0);
                applyStimulus(curCode, 20, 0);
            end else begin
                if (r < 75) begin
                    idx = sectorOf(curCode);
                    if (idx < 0) idx = 0;
                    idx = ($urandom_range(0, 1) == 1) ? (idx + 1) % 6 : (idx + 5) % 6;
                    nxt = hallCodes[idx];
                end else begin
                    nxt = 3'($urandom_range(0, 7));
                end
                hold    = ($urandom_range(0, 19) == 0) ? 300 : $urandom_range(LAT + 1, 160);
                clearAt = ($urandom_range(0, 9) == 0) ? LAT : 0;
                applyStimulus(nxt, hold, clearAt);
                curCode = nxt;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
